// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared macroblock ordering constants and plane type for the
//               motion-compensation pair (mc / mc_recon).
//               Contents:
//                 MC_LUMA_BEATS   - luma rows per macroblock
//                 MC_CHROMA_BEATS - rows per chroma plane (Cb or Cr)
//                 MC_BEAT_CNT_W   - width of the per-plane beat counter
//                 mc_plane_e      - plane currently expected on the input
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    localparam int MC_LUMA_BEATS   = 64;
    localparam int MC_CHROMA_BEATS = 16;
    localparam int MC_BEAT_CNT_W   = 6;

    typedef enum logic [1:0] {
        MC_LUMA = 2'd0,
        MC_CB   = 2'd1,
        MC_CR   = 2'd2
    } mc_plane_e;

endpackage : mc_pkg

`default_nettype wire

// File: rtl/mc_recon_if.sv
// ============================================================================
// Module      : mc_recon_if
// Description : Beat-level bus for mc_recon.
//               Source side : ccin, pred, residual, src_valid -> src_ready
//               Sink side   : recon, ccout, dst_valid, mb_done, seq_err
//                             <- dst_ready
//               master : the environment (drives beats, drives dst_ready)
//               slave  : the reconstruction block
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_recon_if #(
    parameter int MB_SIZE     = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int RES_WIDTH   = 9
);
    logic                           ccin;
    logic [PIXEL_WIDTH*MB_SIZE-1:0] pred;
    logic [RES_WIDTH*MB_SIZE-1:0]   residual;
    logic                           src_valid;
    logic                           src_ready;
    logic [PIXEL_WIDTH*MB_SIZE-1:0] recon;
    logic                           ccout;
    logic                           dst_valid;
    logic                           dst_ready;
    logic                           mb_done;
    logic                           seq_err;

    modport master (
        output ccin, pred, residual, src_valid, dst_ready,
        input  src_ready, recon, ccout, dst_valid, mb_done, seq_err
    );

    modport slave (
        input  ccin, pred, residual, src_valid, dst_ready,
        output src_ready, recon, ccout, dst_valid, mb_done, seq_err
    );

endinterface : mc_recon_if

`default_nettype wire

// File: rtl/mc_recon_fifo.sv
// ============================================================================
// Module      : mc_recon_fifo
// Description : Small synchronous FIFO buffering reconstructed beats.
//               No bypass: a push is refused while full even if a pop
//               happens in the same cycle.
//   clk     in  clock
//   reset   in  asynchronous active-high reset
//   push_i  in  write request (ignored when full)
//   data_i  in  write data
//   pop_i   in  read request (ignored when empty)
//   data_o  out head entry (zero after reset)
//   full_o  out count == DEPTH
//   empty_o out count == 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_recon_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int                PTR_W   = $clog2(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : mc_recon_fifo

`default_nettype wire

// File: rtl/mc_recon.sv
// ============================================================================
// Module      : mc_recon
// Description : Reconstruction stage: recon = clip(pred + residual), one row
//               of MB_SIZE pixels per beat. Tracks macroblock plane order
//               (64 luma, 16 Cb, 16 Cr beats), raises sticky seq_err on a
//               ccin/plane mismatch and pulses mb_done when the final Cr
//               beat leaves the output buffer.
//   clk    in  clock
//   reset  in  asynchronous active-high reset
//   bus    slave modport of mc_recon_if (input beats, output beats,
//          mb_done, seq_err)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_recon
    import mc_pkg::*;
#(
    parameter int MB_SIZE     = 4,
    parameter int PIXEL_WIDTH = 8,
    parameter int RES_WIDTH   = 9,
    parameter int FIFO_DEPTH  = 2
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mc_recon_if.slave  bus
);

    localparam int ROW_W  = PIXEL_WIDTH * MB_SIZE;
    localparam int SUM_W  = RES_WIDTH + 2;
    localparam int DATA_W = ROW_W + 2;

    localparam logic signed [SUM_W-1:0]      PIX_MAX    = SUM_W'((1 << PIXEL_WIDTH) - 1);
    localparam logic [MC_BEAT_CNT_W-1:0]     LUMA_LAST  = MC_BEAT_CNT_W'(MC_LUMA_BEATS - 1);
    localparam logic [MC_BEAT_CNT_W-1:0]     CHROMA_LAST = MC_BEAT_CNT_W'(MC_CHROMA_BEATS - 1);

    logic                     src_ready;
    logic                     accept;
    logic [ROW_W-1:0]         clip_row;
    logic                     last_beat;
    logic                     exp_ccin;

    mc_plane_e                plane_q, plane_d;
    logic [MC_BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                     seq_err_q, seq_err_d;

    logic [DATA_W-1:0]        fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign src_ready     = !reset && !fifo_full;
    assign accept        = bus.src_valid && src_ready;
    assign bus.src_ready = src_ready;

    // ------------------------------------------------------------------
    // Per-pixel add and clip. pred is zero-extended, residual sign-extended,
    // so the sum never overflows SUM_W bits.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < MB_SIZE; i++) begin : g_clip
        logic signed [SUM_W-1:0] pred_ext;
        logic signed [SUM_W-1:0] res_ext;
        logic signed [SUM_W-1:0] sum;
        logic [PIXEL_WIDTH-1:0]  pix;

        assign pred_ext = $signed({{(SUM_W-PIXEL_WIDTH){1'b0}},
                                   bus.pred[i*PIXEL_WIDTH +: PIXEL_WIDTH]});
        assign res_ext  = $signed({{(SUM_W-RES_WIDTH){bus.residual[i*RES_WIDTH+RES_WIDTH-1]}},
                                   bus.residual[i*RES_WIDTH +: RES_WIDTH]});
        assign sum      = pred_ext + res_ext;

        always_comb begin
            pix = sum[PIXEL_WIDTH-1:0];
            if (sum[SUM_W-1]) begin
                pix = '0;
            end else if (sum > PIX_MAX) begin
                pix = '1;
            end
        end

        assign clip_row[i*PIXEL_WIDTH +: PIXEL_WIDTH] = pix;
    end

    // ------------------------------------------------------------------
    // Plane / beat tracker, advanced only on input acceptance.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plane_q    <= MC_LUMA;
            beat_cnt_q <= '0;
            seq_err_q  <= 1'b0;
        end else begin
            plane_q    <= plane_d;
            beat_cnt_q <= beat_cnt_d;
            seq_err_q  <= seq_err_d;
        end
    end

    always_comb begin
        plane_d    = plane_q;
        beat_cnt_d = beat_cnt_q;
        seq_err_d  = seq_err_q;
        exp_ccin   = (plane_q != MC_LUMA);
        last_beat  = (plane_q == MC_CR) && (beat_cnt_q == CHROMA_LAST);

        if (accept) begin
            // A mismatched beat is still reconstructed and counted.
            if (bus.ccin != exp_ccin) begin
                seq_err_d = 1'b1;
            end
            beat_cnt_d = beat_cnt_q + MC_BEAT_CNT_W'(1);
            case (plane_q)
                MC_LUMA: begin
                    if (beat_cnt_q == LUMA_LAST) begin
                        plane_d    = MC_CB;
                        beat_cnt_d = '0;
                    end
                end
                MC_CB: begin
                    if (beat_cnt_q == CHROMA_LAST) begin
                        plane_d    = MC_CR;
                        beat_cnt_d = '0;
                    end
                end
                MC_CR: begin
                    if (beat_cnt_q == CHROMA_LAST) begin
                        plane_d    = MC_LUMA;
                        beat_cnt_d = '0;
                    end
                end
                default: begin
                    plane_d    = MC_LUMA;
                    beat_cnt_d = '0;
                end
            endcase
        end
    end

    assign bus.seq_err = seq_err_q;

    // ------------------------------------------------------------------
    // Output buffer. Entry = {last tag, ccin, recon row}; the last tag
    // turns into mb_done when that entry is popped.
    // ------------------------------------------------------------------
    mc_recon_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .data_i  ({last_beat, bus.ccin, clip_row}),
        .pop_i   (bus.dst_ready),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.dst_valid = !fifo_empty;
    assign bus.recon     = fifo_head[ROW_W-1:0];
    assign bus.ccout     = fifo_head[ROW_W];
    assign bus.mb_done   = !fifo_empty && bus.dst_ready && fifo_head[ROW_W+1];

endmodule : mc_recon

`default_nettype wire

// File: tb/tb_mc_recon.sv
// ============================================================================
// Module      : tb_mc_recon
// Description : Scoreboard bench for mc_recon. The driver pushes the
//               expected output of each accepted beat into a queue; an
//               independent monitor pops and compares on every output
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_recon;

    typedef struct packed {
        logic        last;
        logic        cc;
        logic [31:0] rec;
    } exp_t;

    logic clk;
    logic reset;

    mc_recon_if #(.MB_SIZE(4), .PIXEL_WIDTH(8), .RES_WIDTH(9)) bus ();

    mc_recon #(
        .MB_SIZE     (4),
        .PIXEL_WIDTH (8),
        .RES_WIDTH   (9),
        .FIFO_DEPTH  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   beat_idx = 0;
    int   mb_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] p, input logic [35:0] r);
        logic [31:0] o;
        int s;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            s = int'(p[i*8 +: 8]) + int'($signed(r[i*9 +: 9]));
            o[i*8 +: 8] = (s < 0) ? 8'd0 : (s > 255) ? 8'd255 : 8'(s);
        end
        return o;
    endfunction

    function automatic logic [31:0] pred_of(input int b, input int s);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'((b*29 + i*67 + s*11) & 255);
        return v;
    endfunction

    function automatic logic [35:0] res_of(input int b, input int s);
        logic [35:0] v;
        for (int i = 0; i < 4; i++) v[i*9 +: 9] = 9'((b*53 + i*151 + s*7) & 511);
        return v;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_exp(input logic c, input logic [31:0] p, input logic [35:0] r,
                            input logic [31:0] e);
        int waited;
        waited = 0;
        bus.ccin      = c;
        bus.pred      = p;
        bus.residual  = r;
        bus.src_valid = 1'b1;
        while (!bus.src_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.src_ready) begin
            chk("src_ready_timeout", 64'(bus.src_ready), 64'd1);
            bus.src_valid = 1'b0;
            return;
        end
        exp_q.push_back('{last: (beat_idx == 95), cc: c, rec: e});
        beat_idx = (beat_idx + 1) % 96;
        @(negedge clk);
        bus.src_valid = 1'b0;
    endtask

    task automatic send_beat(input int b, input int s, input logic c);
        send_exp(c, pred_of(b, s), res_of(b, s), model(pred_of(b, s), res_of(b, s)));
    endtask

    task automatic run_mb(input int s, input int from, input int to, input int err_at);
        for (int b = from; b <= to; b++) begin
            send_beat(b, s, (b >= 64) ^ (b == err_at));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.dst_valid && bus.dst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(bus.recon), 64'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    chk("recon",   64'(bus.recon),   64'(e.rec));
                    chk("ccout",   64'(bus.ccout),   64'(e.cc));
                    chk("mb_done", 64'(bus.mb_done), 64'(e.last));
                    if (bus.mb_done) mb_count++;
                end
            end else begin
                chk("mb_done_idle", 64'(bus.mb_done), 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held;
        reset         = 1'b1;
        bus.ccin      = 1'b0;
        bus.pred      = '0;
        bus.residual  = '0;
        bus.src_valid = 1'b0;
        bus.dst_ready = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_dst_valid", 64'(bus.dst_valid), 64'd0);
        chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
        chk("rst_recon",     64'(bus.recon),     64'd0);
        chk("rst_seq_err",   64'(bus.seq_err),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // MB1: basic vector, extremes, then the rest of a clean macroblock
        send_exp(1'b0, {4{8'd100}}, {9'h138, 9'h0C8, 9'h1FB, 9'h005},
                 {8'd0, 8'd255, 8'd95, 8'd105});
        #1;
        chk("latency_dst_valid", 64'(bus.dst_valid), 64'd1);
        @(negedge clk);
        send_exp(1'b0, {4{8'd255}}, {4{9'h0FF}}, 32'hFFFF_FFFF);
        send_exp(1'b0, {4{8'd0}},   {4{9'h100}}, 32'h0000_0000);
        send_exp(1'b0, {8'd17, 8'd200, 8'd0, 8'd255}, 36'd0, {8'd17, 8'd200, 8'd0, 8'd255});
        run_mb(1, 4, 95, -1);
        drain();
        chk("mb1_count",   64'(mb_count),    64'd1);
        chk("mb1_seq_err", 64'(bus.seq_err), 64'd0);

        // MB2: backpressure on the first beats
        bus.dst_ready = 1'b0;
        send_beat(0, 2, 1'b0);
        send_beat(1, 2, 1'b0);
        bus.ccin      = 1'b0;
        bus.pred      = pred_of(2, 2);
        bus.residual  = res_of(2, 2);
        bus.src_valid = 1'b1;
        held = model(pred_of(0, 2), res_of(0, 2));
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_src_ready", 64'(bus.src_ready), 64'd0);
            chk("bp_dst_valid", 64'(bus.dst_valid), 64'd1);
            chk("bp_recon_held", 64'(bus.recon),    64'(held));
            @(negedge clk);
        end
        bus.dst_ready = 1'b1;
        run_mb(2, 2, 95, -1);
        drain();
        chk("mb2_count", 64'(mb_count), 64'd2);

        // MB3: chroma flag on luma beat 10
        run_mb(3, 0, 9, -1);
        chk("seq_err_before", 64'(bus.seq_err), 64'd0);
        send_beat(10, 3, 1'b1);
        chk("seq_err_set", 64'(bus.seq_err), 64'd1);
        run_mb(3, 11, 95, -1);
        drain();
        chk("seq_err_sticky", 64'(bus.seq_err), 64'd1);
        chk("mb3_count", 64'(mb_count), 64'd3);

        // MB4: reset after 30 beats
        run_mb(4, 0, 29, -1);
        reset = 1'b1;
        #1;
        chk("midrst_dst_valid", 64'(bus.dst_valid), 64'd0);
        chk("midrst_src_ready", 64'(bus.src_ready), 64'd0);
        chk("midrst_seq_err",   64'(bus.seq_err),   64'd0);
        exp_q.delete();
        beat_idx = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // MB5: full macroblock after reset; no early mb_done
        run_mb(5, 0, 94, -1);
        drain();
        chk("mb5_no_early_done", 64'(mb_count), 64'd3);
        send_beat(95, 5, 1'b1);
        drain();
        chk("mb5_count", 64'(mb_count), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mc_recon

`default_nettype wire
